id_stage_pipe: RTL
==================

Name: id_stage_pipe

Overview:
- Parametrised, registered successor to the combinational decode stage.
- Decodes one instruction per cycle using the existing `id_control` and `id_sign_extend` units, and holds the result in an ID/EX pipeline register.
- Adds valid/ready handshakes on both sides, load-use hazard stalling, flush, and a correct shift-amount select.
- Sits between the IF stage and EX.

Parameters:
- XLEN, 32, width of pc, immediate and branch address datapaths.
- CTRL_W, 13, width of the control bundle {mem_read, mem_write, alu_src_a, alu_src_b, mem_to_reg[1:0], alu_op[3:0], reg_write, jump[1:0]}.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- in_valid  in  1  IF presents an instruction.
- in_ready  out  1  stage accepts the instruction this cycle.
- in_inst  in  32  instruction word.
- in_pc  in  XLEN  instruction address.
- flush  in  1  squash from EX (taken branch or jump).
- out_valid  out  1  ID/EX register holds a valid instruction.
- out_ready  in  1  EX consumes the register this cycle.
- out_controls  out  CTRL_W  registered control bundle.
- out_is_signed  out  1  registered load/compare signedness.
- out_inst_size  out  2  registered memory access size.
- out_imm  out  XLEN  shamt (zero-extended) or sign-extended immediate.
- out_branch_addr  out  XLEN  in_pc + sign-extended immediate, modulo 2^XLEN.
- out_pc  out  XLEN  registered pc.
- out_rs1, out_rs2, out_rd  out  5 each  register fields inst[19:15], inst[24:20], inst[11:7].
- redirect_valid  out  1  early-jump redirect (optional feature).
- redirect_addr  out  XLEN  early-jump target (optional feature).

Behaviour:
- Reset (reset==0 at clk edge): out_valid=0, all payload registers=0, redirect_valid=0, redirect_addr=0. Reset mid-stall or mid-backpressure discards all held state.
- Decode is combinational from in_inst; its results are registered on accept. Latency is 1 cycle from accept to out_valid.
- Shift amount: for opcode 0010011 with funct3 001 or 101, out_imm = {0, inst[24:20]}. Otherwise out_imm = sign-extended immediate. No X-comparison is used for this select.
- Hazard: hazard = out_valid & out_controls.mem_read & (out_rd!=0) & (in_inst[19:15]==out_rd | in_inst[24:20]==out_rd). Both source fields are compared regardless of format.
- in_ready = ~hazard & (~out_valid | out_ready) when flush==0. in_ready = 1 when flush==1.
- Accept = in_valid & in_ready & ~flush. On accept: load payload, out_valid<=1.
- Register update priority, highest first:
  1. flush → out_valid<=0; any input presented this cycle is dropped.
  2. accept → load new payload.
  3. out_ready & out_valid (no accept) → out_valid<=0. This produces the bubble when hazard=1, giving exactly one bubble cycle per load-use pair.
  4. otherwise → hold all registers unchanged.
- Backpressure: while out_valid & ~out_ready, every out_* value is stable.
- Simultaneous out_ready and accept: back-to-back streaming at 1 instruction/cycle.
- Invalid input (in_valid==0) never sets out_valid.

Optional Feature:
- Macro: ID_EARLY_JUMP_EN.
- Defined: on accept of a JAL (opcode 1101111), redirect_valid pulses 1 for exactly the following cycle, with redirect_addr = in_pc + J-immediate latched at accept. No pulse if flush is asserted in the accept cycle. redirect_valid is 0 in all other cycles.
- Undefined: redirect_valid and redirect_addr are tied to 0; no extra logic.

Test Plan:
- Reset then addi x1,x0,5 (0x00500093) @pc 0x100, out_ready=1 → next cycle out_valid=1, out_imm=5, out_rd=1, out_rs1=0, out_pc=0x100.
- srli x3,x4,7 (0x00725193) → out_imm=0x00000007. srai x3,x4,7 (0x40725193) → out_imm=7 as well.
- lw x5,0(x2) (0x00012283) followed by add x6,x5,x1 (0x00128333) →
  - in_ready=0 for exactly one cycle; out_valid=0 for one cycle after the lw.
  - the add then appears with out_rs1=5.
  - repeat with rd=x0 → no stall.
- out_ready=0 for 3 cycles with beq x1,x2,+8 (0x00208463) @pc 0x40 held → out_branch_addr=0x48 and all outputs stable for those 3 cycles; in_ready=0.
- flush asserted in the same cycle as in_valid with an instruction present → next cycle out_valid=0; the dropped instruction never appears.
- With ID_EARLY_JUMP_EN: jal x1,16 (0x010000EF) @pc 0x200 → one-cycle redirect_valid=1, redirect_addr=0x210. Without the macro → redirect_valid stays 0.

Source files
------------

// File: rtl/id_stage_pipe_if.sv
// id_stage_pipe_if: IF-side and EX-side handshake/payload bundle of the
// registered decode stage. master = IF/EX environment, slave = id_stage_pipe.
interface id_stage_pipe_if #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 13
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_inst;
    logic [XLEN-1:0]   in_pc;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_controls;
    logic              out_is_signed;
    logic [1:0]        out_inst_size;
    logic [XLEN-1:0]   out_imm;
    logic [XLEN-1:0]   out_branch_addr;
    logic [XLEN-1:0]   out_pc;
    logic [4:0]        out_rs1;
    logic [4:0]        out_rs2;
    logic [4:0]        out_rd;
    logic              redirect_valid;
    logic [XLEN-1:0]   redirect_addr;

    modport master (
        output in_valid, in_inst, in_pc, flush, out_ready,
        input  in_ready, out_valid, out_controls, out_is_signed,
        input  out_inst_size, out_imm, out_branch_addr, out_pc,
        input  out_rs1, out_rs2, out_rd, redirect_valid, redirect_addr
    );

    modport slave (
        input  in_valid, in_inst, in_pc, flush, out_ready,
        output in_ready, out_valid, out_controls, out_is_signed,
        output out_inst_size, out_imm, out_branch_addr, out_pc,
        output out_rs1, out_rs2, out_rd, redirect_valid, redirect_addr
    );
endinterface

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: RV32 decode with an ID/EX register, valid/ready on both
// sides, load-use stall and flush.
// Ports: clk, reset (sync, active-low), bus (id_stage_pipe_if.slave).
// Optional macro ID_EARLY_JUMP_EN: one-cycle JAL redirect pulse.
module id_stage_pipe #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 13
) (
    input logic            clk,
    input logic            reset,
    id_stage_pipe_if.slave bus
);
    logic [31:0] inst;
    logic [6:0]  opcode;
    logic [2:0]  f3;
    assign inst   = bus.in_inst;
    assign opcode = inst[6:0];
    assign f3     = inst[14:12];

    logic is_r, is_opi, is_ld, is_st, is_br;
    logic is_jal, is_jalr, is_lui, is_auipc, is_shift;
    assign is_r     = opcode == 7'b0110011;
    assign is_opi   = opcode == 7'b0010011;
    assign is_ld    = opcode == 7'b0000011;
    assign is_st    = opcode == 7'b0100011;
    assign is_br    = opcode == 7'b1100011;
    assign is_jal   = opcode == 7'b1101111;
    assign is_jalr  = opcode == 7'b1100111;
    assign is_lui   = opcode == 7'b0110111;
    assign is_auipc = opcode == 7'b0010111;
    assign is_shift = is_opi & (f3 == 3'b001 | f3 == 3'b101);

    logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;
    assign i_imm = {{20{inst[31]}}, inst[31:20]};
    assign s_imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign b_imm = {{19{inst[31]}}, inst[31], inst[7],
                    inst[30:25], inst[11:8], 1'b0};
    assign u_imm = {inst[31:12], 12'b0};
    assign j_imm = {{11{inst[31]}}, inst[31], inst[19:12],
                    inst[20], inst[30:21], 1'b0};

    logic        mem_read, mem_write, src_a, src_b, reg_write;
    logic [1:0]  m2r, jump, size_d;
    logic [3:0]  alu_op;
    logic        sgn_d;
    logic [31:0] imm32;

    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        src_a     = 1'b0;
        src_b     = 1'b0;
        m2r       = 2'b00;
        alu_op    = 4'b0000;
        reg_write = 1'b0;
        jump      = 2'b00;
        sgn_d     = 1'b0;
        size_d    = 2'b00;
        imm32     = i_imm;
        unique case (1'b1)
            is_r: begin
                reg_write = 1'b1;
                alu_op    = {inst[30], f3};
            end
            is_opi: begin
                reg_write = 1'b1;
                src_b     = 1'b1;
                // inst[30] is an immediate bit except for srai
                alu_op    = {is_shift & inst[30], f3};
            end
            is_ld: begin
                mem_read  = 1'b1;
                reg_write = 1'b1;
                src_b     = 1'b1;
                m2r       = 2'b01;
                size_d    = f3[1:0];
                sgn_d     = ~f3[2];
            end
            is_st: begin
                mem_write = 1'b1;
                src_b     = 1'b1;
                size_d    = f3[1:0];
                imm32     = s_imm;
            end
            is_br: begin
                alu_op = 4'b1000;
                sgn_d  = ~f3[1];
                imm32  = b_imm;
            end
            is_jal: begin
                reg_write = 1'b1;
                m2r       = 2'b10;
                jump      = 2'b01;
                imm32     = j_imm;
            end
            is_jalr: begin
                reg_write = 1'b1;
                src_b     = 1'b1;
                m2r       = 2'b10;
                jump      = 2'b10;
            end
            is_lui: begin
                reg_write = 1'b1;
                src_b     = 1'b1;
                alu_op    = 4'b1111;
                imm32     = u_imm;
            end
            is_auipc: begin
                reg_write = 1'b1;
                src_a     = 1'b1;
                src_b     = 1'b1;
                imm32     = u_imm;
            end
            default: ;
        endcase
    end

    logic [CTRL_W-1:0] ctrl_d;
    logic [XLEN-1:0]   imm_sext, imm_d, branch_d;
    assign ctrl_d   = CTRL_W'({mem_read, mem_write, src_a, src_b, m2r,
                               alu_op, reg_write, jump});
    assign imm_sext = XLEN'($signed(imm32));
    assign imm_d    = is_shift ? XLEN'(inst[24:20]) : imm_sext;
    assign branch_d = bus.in_pc + imm_sext;

    // Load in ID/EX whose rd feeds either source field of the incoming word
    logic hazard, accept;
    assign hazard = bus.out_valid & bus.out_controls[CTRL_W-1]
                  & (bus.out_rd != 5'd0)
                  & (inst[19:15] == bus.out_rd | inst[24:20] == bus.out_rd);
    assign bus.in_ready = bus.flush
                        | (~hazard & (~bus.out_valid | bus.out_ready));
    assign accept = bus.in_valid & bus.in_ready & ~bus.flush;

    always_ff @(posedge clk) begin
        if (!reset) begin
            bus.out_valid       <= 1'b0;
            bus.out_controls    <= '0;
            bus.out_is_signed   <= 1'b0;
            bus.out_inst_size   <= 2'b00;
            bus.out_imm         <= '0;
            bus.out_branch_addr <= '0;
            bus.out_pc          <= '0;
            bus.out_rs1         <= 5'd0;
            bus.out_rs2         <= 5'd0;
            bus.out_rd          <= 5'd0;
        end else if (bus.flush) begin
            bus.out_valid <= 1'b0;
        end else if (accept) begin
            bus.out_valid       <= 1'b1;
            bus.out_controls    <= ctrl_d;
            bus.out_is_signed   <= sgn_d;
            bus.out_inst_size   <= size_d;
            bus.out_imm         <= imm_d;
            bus.out_branch_addr <= branch_d;
            bus.out_pc          <= bus.in_pc;
            bus.out_rs1         <= inst[19:15];
            bus.out_rs2         <= inst[24:20];
            bus.out_rd          <= inst[11:7];
        end else if (bus.out_ready & bus.out_valid) begin
            bus.out_valid <= 1'b0;
        end
    end

`ifdef ID_EARLY_JUMP_EN
    // For JAL the branch adder already yields pc + J-immediate
    always_ff @(posedge clk) begin
        if (!reset) begin
            bus.redirect_valid <= 1'b0;
            bus.redirect_addr  <= '0;
        end else begin
            bus.redirect_valid <= accept & is_jal;
            if (accept & is_jal)
                bus.redirect_addr <= branch_d;
        end
    end
`else
    assign bus.redirect_valid = 1'b0;
    assign bus.redirect_addr  = '0;
`endif
endmodule
